// File: rtl/adc_window_acc_if.sv
// Result channel of the ADC window accumulator.
// A one-entry valid/ready register carrying the tagged window sum.
interface adc_window_acc_if #(
  parameter int DATA_W = 12
);
  logic              res_vld;
  logic              res_rdy;
  logic [DATA_W+5:0] res_sum;
  logic [5:0]        res_cnt;
  logic [1:0]        res_ch;
  logic              res_err;
  logic [9:0]        res_rot;

  modport master (
    output res_vld,
    output res_sum,
    output res_cnt,
    output res_ch,
    output res_err,
    output res_rot,
    input  res_rdy
  );

  modport slave (
    input  res_vld,
    input  res_sum,
    input  res_cnt,
    input  res_ch,
    input  res_err,
    input  res_rot,
    output res_rdy
  );
endinterface

// File: rtl/adc_window_acc.sv
// Accumulates ADC samples per adc_en window, tags them with RF path
// and rotation, and hands the result over a one-entry valid/ready reg.
module adc_window_acc #(
  parameter int DATA_W = 12
) (
  input  logic              stp_clk,
  input  logic              sys_init_n,
  input  logic              adc_en,
  input  logic [3:0]        rf_sw,
  input  logic [9:0]        rot_count,
  input  logic              adc_vld,
  input  logic [DATA_W-1:0] adc_data,
  adc_window_acc_if.master  res,
  output logic              ovf,
  output logic [7:0]        drop_cnt
);

  localparam int ACC_W = DATA_W + 6;

  typedef enum logic {
    IDLE,
    ACC
  } state_t;

  state_t state_q, state_d;

  logic [ACC_W-1:0] sum_q;
  logic [5:0]       cnt_q;
  logic [1:0]       ch_q;
  logic             err_q;
  logic [9:0]       rot_q;

  logic [1:0] ch_enc;
  logic       ch_bad;
  logic       open;
  logic       close;
  logic       take;
  logic       full;
  logic       sat_hit;
  logic       xfer;
  logic       load;
  logic       drop;

  always_comb begin
    ch_enc = 2'd0;
    ch_bad = 1'b0;
    case (rf_sw)
      4'b0001: ch_enc = 2'd0;
      4'b0010: ch_enc = 2'd1;
      4'b0100: ch_enc = 2'd2;
      4'b1000: ch_enc = 2'd3;
      default: ch_bad = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    open    = 1'b0;
    close   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (adc_en) begin
          open    = 1'b1;
          state_d = ACC;
        end
      end
      ACC: begin
        if (!adc_en) begin
          close   = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  assign take    = adc_vld & adc_en & (state_q == ACC);
  assign full    = (cnt_q == 6'd63);
  assign sat_hit = take & full;
  assign xfer    = res.res_vld & res.res_rdy;
  // Output slot is free if empty or draining on this same edge.
  assign load    = close & (~res.res_vld | res.res_rdy);
  assign drop    = close & ~load;

  always_ff @(posedge stp_clk or negedge sys_init_n) begin
    if (!sys_init_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge stp_clk or negedge sys_init_n) begin
    if (!sys_init_n) begin
      sum_q <= '0;
      cnt_q <= '0;
      ch_q  <= '0;
      err_q <= 1'b0;
      rot_q <= '0;
    end else if (open) begin
      ch_q  <= ch_enc;
      err_q <= ch_bad;
      rot_q <= rot_count;
      sum_q <= adc_vld ? ACC_W'(adc_data) : '0;
      cnt_q <= adc_vld ? 6'd1 : 6'd0;
    end else if (take && !full) begin
      sum_q <= sum_q + ACC_W'(adc_data);
      cnt_q <= cnt_q + 6'd1;
    end
  end

  always_ff @(posedge stp_clk or negedge sys_init_n) begin
    if (!sys_init_n) begin
      res.res_vld <= 1'b0;
      res.res_sum <= '0;
      res.res_cnt <= '0;
      res.res_ch  <= '0;
      res.res_err <= 1'b0;
      res.res_rot <= '0;
    end else if (load) begin
      res.res_vld <= 1'b1;
      res.res_sum <= sum_q;
      res.res_cnt <= cnt_q;
      res.res_ch  <= ch_q;
      res.res_err <= err_q;
      res.res_rot <= rot_q;
    end else if (xfer) begin
      res.res_vld <= 1'b0;
    end
  end

  always_ff @(posedge stp_clk or negedge sys_init_n) begin
    if (!sys_init_n) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (sat_hit || drop) begin
        ovf <= 1'b1;
      end
      if (drop && drop_cnt != 8'hff) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule

// File: doc/adc_window_acc.md
# adc_window_acc

Capture stage directly downstream of the measurement sequencer. During each `adc_en` window it accumulates ADC samples and tags the window with the active RF path (`rf_sw`) and rotation index (`rot_count`). At window close it presents the tagged sum and sample count through a one-entry valid/ready output register for the readout logic. Windows that close while the previous result is still unconsumed are counted and dropped.

## Interface
- `DATA_W`, 12, ADC sample width; accumulator width is fixed at `DATA_W+6`.

- `stp_clk`  in  1  system step clock; all logic on rising edge.
- `sys_init_n`  in  1  asynchronous active-low reset.
- `adc_en`  in  1  sample window gate from the sequencer; level, synchronous to `stp_clk`.
- `rf_sw`  in  4  RF switch one-hot, sampled at window open.
- `rot_count`  in  10  rotation index, sampled at window open.
- `adc_vld`  in  1  ADC sample strobe.
- `adc_data`  in  `DATA_W`  unsigned ADC sample.
- `res_rdy`  in  1  downstream ready.
- `res_vld`  out  1  result valid.
- `res_sum`  out  `DATA_W+6`  sum of accepted samples.
- `res_cnt`  out  6  accepted sample count.
- `res_ch`  out  2  encoded channel: 0001→0, 0010→1, 0100→2, 1000→3.
- `res_err`  out  1  `rf_sw` was not exactly one-hot at window open.
- `res_rot`  out  10  latched `rot_count`.
- `ovf`  out  1  sticky flag: sample count saturated, or a window was dropped.
- `drop_cnt`  out  8  saturating count of dropped windows.

## Operation
- **Reset values:** every output and internal register is 0. State is IDLE. Reset acts immediately on assertion, including mid-window; a partial window is discarded with no result.
- **IDLE:** on a cycle with `adc_en`=1:
  - latch encoded `rf_sw` into the channel tag and `rot_count` into the rotation tag;
  - set the err tag when `rf_sw` is not one-hot, with channel tag 0;
  - clear the accumulator and count, then go to ACC.
  - If `adc_vld`=1 in that same cycle, that sample is the first accepted sample.
- **ACC:** each cycle with `adc_en`=1 and `adc_vld`=1:
  - if count < 63: sum += `adc_data` and count += 1;
  - if count = 63: the sample is ignored and `ovf` is set.
  - The sum cannot overflow: 63 × (2^DATA_W−1) < 2^(DATA_W+6).
- **Window close:** the first ACC cycle with `adc_en`=0. The state returns to IDLE, and `adc_vld` in that cycle is ignored. The result is then handled as follows:
  - If the output register is free (`res_vld`=0, or `res_vld`=1 with `res_rdy`=1 in the same cycle), it loads sum, count, channel, err and rotation tags, and `res_vld` goes to 1.
  - Otherwise the window is dropped: `drop_cnt` += 1 (saturating at 255), `ovf` is set, and the held result is unchanged.
- **Output handshake:**
  - Transfer occurs when `res_vld` & `res_rdy`; `res_vld` then clears unless a close loads new data in the same cycle.
  - All `res_*` outputs hold stable while `res_vld`=1 and `res_rdy`=0.
- **Empty windows:** a window with zero accepted samples still produces a result with `res_cnt`=0 and `res_sum`=0.
- **Sticky state:** `ovf` and `drop_cnt` clear only on reset.

## Timing
- **Result latency:** `res_vld` rises on the clock edge that samples `adc_en`=0 in ACC, i.e. 1 cycle after the last `adc_en`=1 cycle.
- **Minimum gap:** 1 cycle of `adc_en`=0 separates two windows. A close followed by a reopen on the next cycle is legal.
- **Tag timing:** tags come from the opening cycle only. Changes to `rf_sw` or `rot_count` inside a window have no effect.
- **Throughput:** one result per window. `res_rdy` may be held low indefinitely.

## Test plan
- **Basic window:** `rf_sw`=0001, `rot_count`=5, `adc_en` high 30 cycles, `adc_vld`=1 every cycle, data=100 → `res_sum`=3000, `res_cnt`=30, `res_ch`=0, `res_rot`=5, `res_err`=0. `res_vld` rises 1 cycle after `adc_en` falls and holds until `res_rdy`.
- **Backpressure:** `res_rdy`=0 across two windows (sums 3000, then 600) → held result stays 3000, `drop_cnt`=1, `ovf`=1. After `res_rdy`=1 for one cycle, `res_vld`=0.
- **Count saturation:** 70 samples of 4095 → `res_cnt`=63, `res_sum`=257985, `ovf`=1.
- **Bad RF select:** `rf_sw`=0011 at open → `res_err`=1, `res_ch`=0. Changing `rf_sw` to 1000 mid-window does not alter the tag.
- **Close coincident with handshake:** prior result pending, `res_rdy`=1 in the close cycle → new result loaded, `drop_cnt` unchanged, `res_vld` stays 1.
- **Reset mid-window:** `sys_init_n` low at sample 10 → all outputs 0 immediately. A subsequent 5-sample window of 7 yields `res_sum`=35, `res_cnt`=5.
